// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the programmable sync FIFO.
package fifo_pkg;

   localparam int unsigned FWFT_OFF = 0;
   localparam int unsigned FWFT_ON  = 1;

   localparam int unsigned ADDRSIZE_DEF = 4;
   localparam int unsigned CNTSIZE_DEF  = ADDRSIZE_DEF + 1;

   function automatic int unsigned fifo_depth(input int unsigned addrsize);
      return 32'(1) << addrsize;
   endfunction

   // Fill level spans 0..DEPTH inclusive, hence one extra bit over the address.
   function automatic int unsigned fifo_cnt_width(input int unsigned addrsize);
      return addrsize + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned ADDRSIZE = 4
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [ADDRSIZE-1:0] i_waddr,
   input  logic [DATASIZE-1:0] i_wdata,
   input  logic [ADDRSIZE-1:0] i_raddr,
   output logic [DATASIZE-1:0] o_rdata
);

   localparam int unsigned DEPTH = fifo_depth(ADDRSIZE);

   logic [DATASIZE-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, fill level,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned ADDRSIZE = 4,
   parameter int unsigned FWFT     = FWFT_OFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATASIZE-1:0]   wdata,
   input  logic                  winc,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [DATASIZE-1:0]   rdata,
   input  logic                  rinc,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [ADDRSIZE:0]     count,
   input  logic [ADDRSIZE:0]     afull_thresh,
   input  logic [ADDRSIZE:0]     aempty_thresh,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int unsigned DEPTH   = fifo_depth(ADDRSIZE);
   localparam int unsigned CNTSIZE = fifo_cnt_width(ADDRSIZE);

   logic [ADDRSIZE-1:0] r_wptr;
   logic [ADDRSIZE-1:0] r_rptr;
   logic [CNTSIZE-1:0]  r_count;
   logic                r_wfull;
   logic                r_rempty;
   logic                r_walmost_full;
   logic                r_ralmost_empty;
   logic                r_overflow;
   logic                r_underflow;

   logic                w_wr_acc;
   logic                w_rd_acc;
   logic [CNTSIZE-1:0]  w_cnt_nxt;
   logic [DATASIZE-1:0] w_mem_rdata;

   // Acceptance uses the registered flags, i.e. the state before the edge.
   assign w_wr_acc = winc & ~r_wfull;
   assign w_rd_acc = rinc & ~r_rempty;

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_cnt_nxt = r_count + CNTSIZE'(1);
      else if (!w_wr_acc && w_rd_acc)
         w_cnt_nxt = r_count - CNTSIZE'(1);
   end

   fifo_mem #(
      .DATASIZE (DATASIZE),
      .ADDRSIZE (ADDRSIZE)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr),
      .i_wdata (wdata),
      .i_raddr (r_rptr),
      .o_rdata (w_mem_rdata)
   );

   // Flags follow next-state count so they move on the same edge as count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_count         <= '0;
         r_wfull         <= 1'b0;
         r_rempty        <= 1'b1;
         r_walmost_full  <= 1'b0;
         r_ralmost_empty <= 1'b1;
         r_overflow      <= 1'b0;
         r_underflow     <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + ADDRSIZE'(1);
         if (w_rd_acc) r_rptr <= r_rptr + ADDRSIZE'(1);
         r_count         <= w_cnt_nxt;
         r_wfull         <= (w_cnt_nxt == CNTSIZE'(DEPTH));
         r_rempty        <= (w_cnt_nxt == '0);
         r_walmost_full  <= (w_cnt_nxt >= afull_thresh);
         r_ralmost_empty <= (w_cnt_nxt <= aempty_thresh);

         // Setting wins over a same-cycle clear.
         if (winc && r_wfull)   r_overflow  <= 1'b1;
         else if (err_clr)      r_overflow  <= 1'b0;
         if (rinc && r_rempty)  r_underflow <= 1'b1;
         else if (err_clr)      r_underflow <= 1'b0;
      end
   end

   generate
      if (FWFT == FWFT_ON) begin : g_fwft
         // Head of queue presented directly; forced to zero while empty.
         assign rdata = r_rempty ? '0 : w_mem_rdata;
      end else begin : g_std
         logic [DATASIZE-1:0] r_rdata;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           r_rdata <= '0;
            else if (w_rd_acc) r_rdata <= w_mem_rdata;
         end
         assign rdata = r_rdata;
      end
   endgenerate

   assign wfull         = r_wfull;
   assign rempty        = r_rempty;
   assign walmost_full  = r_walmost_full;
   assign ralmost_empty = r_ralmost_empty;
   assign count         = r_count;
   assign overflow      = r_overflow;
   assign underflow     = r_underflow;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock, parametrised successor to the team's async FIFO.
- Adds generic width and depth, run-time programmable almost-full and almost-empty thresholds, a fill-level output, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Used as the intra-domain buffer between same-clock pipeline stages. The async FIFO remains the clock-domain-crossing part.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE entries (16 by default).
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wdata  in  DATASIZE  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO holds DEPTH entries.
- walmost_full  out  1  count >= afull_thresh.
- rdata  out  DATASIZE  read data.
- rinc  in  1  read request (pop).
- rempty  out  1  FIFO holds 0 entries.
- ralmost_empty  out  1  count <= aempty_thresh.
- count  out  ADDRSIZE+1  current fill level, 0..DEPTH.
- afull_thresh  in  ADDRSIZE+1  almost-full threshold; sampled every cycle.
- aempty_thresh  in  ADDRSIZE+1  almost-empty threshold; sampled every cycle.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - wptr = rptr = 0, count = 0.
  - rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0.
  - rdata = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared. Reset mid-operation discards all stored entries.
- Flags after reset release are derived from count with the thresholds live. If afull_thresh = 0, walmost_full is 1 from the first cycle out of reset.
- Write accepted = winc & ~wfull. Read accepted = rinc & ~rempty. Flags seen are those valid before the edge.
- On each accepted write: mem[wptr] <= wdata; wptr increments modulo DEPTH.
- On each accepted read: rptr increments modulo DEPTH.
- Pointers are ADDRSIZE bits and wrap naturally from DEPTH-1 to 0.
- count update is registered:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous write and read while full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
- Simultaneous write and read while empty: write accepted, read rejected, underflow set, count becomes 1.
- Flags are registered and computed from next-state count, so they change on the same edge as count:
  - wfull = (count == DEPTH).
  - rempty = (count == 0).
  - walmost_full = (count >= afull_thresh).
  - ralmost_empty = (count <= aempty_thresh).
- A threshold change takes effect on the next clock edge.
- FWFT = 0: rdata <= mem[rptr] on the edge of an accepted read, so data is valid 1 cycle after the read. rdata holds its value when no read is accepted.
- FWFT = 1: rdata continuously presents mem[rptr] (the head) whenever rempty = 0; rinc pops it.
  - Data written at edge N is visible on rdata after edge N.
  - rdata is don't-care while rempty = 1. The bench must not check it then.
- overflow: set on winc & wfull. underflow: set on rinc & rempty.
- Both error flags stay set until err_clr = 1 or reset. Set has priority over err_clr in the same cycle.
- A rejected access changes no pointer, no count and no memory location.

Decomposition:
- Package fifo_pkg holds:
  - depth function (ADDRSIZE to DEPTH);
  - count-width localparam (ADDRSIZE+1);
  - read-mode constants FWFT_OFF = 0 and FWFT_ON = 1.
- One sub-module, fifo_mem: simple dual-port RAM with one write port and an async read port, parametrised by DATASIZE and ADDRSIZE. The FWFT=0 output register lives in sync_fifo_prog, not in fifo_mem.
- Pointers, count, flags and error logic stay in the top module.

Test Plan (DATASIZE=8, ADDRSIZE=4, afull_thresh=14, aempty_thresh=2 unless noted):
- Reset then idle:
  - count = 0, rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0, rdata = 00.
- Write 16 words 00..0F back-to-back, FWFT=0:
  - walmost_full rises on the edge where count becomes 14.
  - wfull rises when count = 16.
  - A 17th write sets overflow; count stays 16.
- Read all 16 words, FWFT=0:
  - rdata = 00..0F in order, each 1 cycle after its rinc.
  - ralmost_empty rises at count = 2; rempty rises at count = 0.
  - An extra rinc sets underflow. err_clr then clears both error flags.
- Simultaneous winc and rinc for 40 cycles at count = 5:
  - count stays 5; read data order is preserved across pointer wrap.
- FWFT=1, one write of A5 into an empty FIFO:
  - rdata = A5 and rempty = 0 the cycle after the write.
  - rinc pops it and rempty returns to 1.
- Assert rst mid-stream at count = 9:
  - All outputs immediately take their reset values.
  - The first write after release reads back correctly.
